// File: rtl/ecc_scrubber.sv
// Background SECDED scrubber sitting in front of a single-port SRAM bank; the host port always has priority.
// Codeword layout: bit 0 = overall parity, bits 1..EncWidth-1 = Hamming positions with check bits at powers of two.
module ecc_scrubber #(
    parameter int DataWidth     = 32,
    parameter int NumWords      = 256,
    parameter int ScrubInterval = 1024,
    parameter int CntWidth      = 16,
    localparam int ParWidth     = $clog2(DataWidth + $clog2(DataWidth) + 1),
    localparam int EncWidth     = DataWidth + ParWidth + 1,
    localparam int AddrWidth    = $clog2(NumWords)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 host_req_i,
    output logic                 host_gnt_o,
    input  logic                 host_we_i,
    input  logic [AddrWidth-1:0] host_addr_i,
    input  logic [EncWidth-1:0]  host_wdata_i,
    output logic [EncWidth-1:0]  host_rdata_o,
    output logic                 bank_req_o,
    output logic                 bank_we_o,
    output logic [AddrWidth-1:0] bank_addr_o,
    output logic [EncWidth-1:0]  bank_wdata_o,
    input  logic [EncWidth-1:0]  bank_rdata_i,
    output logic                 scrub_busy_o,
    output logic [CntWidth-1:0]  corr_cnt_o,
    output logic [CntWidth-1:0]  uncorr_cnt_o,
    output logic                 uncorr_valid_o,
    output logic [AddrWidth-1:0] uncorr_addr_o
);
    // state  | meaning
    // IDLE   | counting idle cycles until the next scrub
    // READ   | waiting for a host-free cycle to read the pointer word
    // DECODE | read data valid, check and classify it
    // WRITE  | waiting for a host-free cycle to write back the corrected word
    typedef enum logic [1:0] {IDLE, READ, DECODE, WRITE} state_t;

    localparam int IvlWidth = $clog2(ScrubInterval + 1);

    state_t                state;
    logic [IvlWidth-1:0]   ivl_cnt;
    logic [AddrWidth-1:0]  ptr;
    logic [AddrWidth-1:0]  ptr_next;
    logic [EncWidth-1:0]   fix_word;
    logic [ParWidth-1:0]   syndrome;
    logic                  overall;
    logic                  single_err;
    logic                  double_err;
    logic [EncWidth-1:0]   corrected;
    logic                  host_hit;

    always_comb begin
        syndrome = '0;
        for (int i = 1; i < EncWidth; i++) begin
            if (bank_rdata_i[i]) syndrome = syndrome ^ ParWidth'(i);
        end
        overall = ^bank_rdata_i;
        // Odd parity pointing outside the codeword cannot be a single flip.
        single_err = overall && (32'(syndrome) < EncWidth);
        double_err = (!overall && syndrome != '0) || (overall && !single_err);
        corrected  = bank_rdata_i ^ (EncWidth'(1) << syndrome);
    end

    assign ptr_next = (ptr == AddrWidth'(NumWords - 1)) ? '0 : ptr + AddrWidth'(1);
    assign host_hit = host_req_i && host_we_i && (host_addr_i == ptr);

    assign host_gnt_o     = host_req_i;
    assign host_rdata_o   = bank_rdata_i;
    assign scrub_busy_o   = (state != IDLE);
    assign uncorr_valid_o = (state == DECODE) && double_err;

    always_comb begin
        bank_req_o   = 1'b0;
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        if (host_req_i) begin
            bank_req_o   = 1'b1;
            bank_we_o    = host_we_i;
            bank_addr_o  = host_addr_i;
            bank_wdata_o = host_wdata_i;
        end else if (state == READ) begin
            bank_req_o  = 1'b1;
            bank_addr_o = ptr;
        end else if (state == WRITE) begin
            bank_req_o   = 1'b1;
            bank_we_o    = 1'b1;
            bank_addr_o  = ptr;
            bank_wdata_o = fix_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            ivl_cnt       <= '0;
            ptr           <= '0;
            fix_word      <= '0;
            corr_cnt_o    <= '0;
            uncorr_cnt_o  <= '0;
            uncorr_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!enable_i) begin
                        ivl_cnt <= '0;
                    end else if (ivl_cnt == IvlWidth'(ScrubInterval - 1)) begin
                        ivl_cnt <= '0;
                        state   <= READ;
                    end else begin
                        ivl_cnt <= ivl_cnt + IvlWidth'(1);
                    end
                end
                READ: begin
                    if (!host_req_i) state <= DECODE;
                end
                DECODE: begin
                    if (double_err) begin
                        uncorr_addr_o <= ptr;
                        if (uncorr_cnt_o != '1) uncorr_cnt_o <= uncorr_cnt_o + CntWidth'(1);
                        ptr   <= ptr_next;
                        state <= IDLE;
                    end else if (single_err && !host_hit) begin
                        fix_word <= corrected;
                        state    <= WRITE;
                    end else begin
                        // Clean word, or the host is overwriting it right now.
                        ptr   <= ptr_next;
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (host_hit) begin
                        ptr   <= ptr_next;
                        state <= IDLE;
                    end else if (!host_req_i) begin
                        if (corr_cnt_o != '1) corr_cnt_o <= corr_cnt_o + CntWidth'(1);
                        ptr   <= ptr_next;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_scrubber.sv
// Directed bench for ecc_scrubber: SRAM model, bank-access log, vector tables plus corner-case sequences.
module tb_ecc_scrubber;
    localparam int DW = 32, NW = 8, SI = 4, CW = 16, EW = 39, AW = 3;

    logic          clk = 1'b0;
    logic          rst, enable, host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [EW-1:0] host_wdata, host_rdata, bank_wdata, rdata;
    logic          host_gnt, bank_req, bank_we, scrub_busy, uncorr_valid;
    logic [AW-1:0] bank_addr, uncorr_addr;
    logic [CW-1:0] corr_cnt, uncorr_cnt;

    always #5 clk = ~clk;

    ecc_scrubber #(.DataWidth(DW), .NumWords(NW), .ScrubInterval(SI), .CntWidth(CW)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_we_i(host_we),
        .host_addr_i(host_addr), .host_wdata_i(host_wdata), .host_rdata_o(host_rdata),
        .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
        .bank_wdata_o(bank_wdata), .bank_rdata_i(rdata),
        .scrub_busy_o(scrub_busy), .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt),
        .uncorr_valid_o(uncorr_valid), .uncorr_addr_o(uncorr_addr)
    );

    typedef struct {int cyc; bit we; int addr; logic [EW-1:0] wdata;} acc_t;
    typedef struct {
        logic req; logic we; logic [AW-1:0] addr; logic [EW-1:0] wdata;
        logic exp_req; logic exp_we; logic [AW-1:0] exp_addr; logic [EW-1:0] exp_wdata;
    } mux_vec_t;
    typedef struct {int addr; logic [EW-1:0] flip; bit exp_write; int exp_uncorr;} ecc_vec_t;

    logic [EW-1:0] mem [NW];
    acc_t          log_q[$];
    int            cyc = 0, upulse = 0, pulse_base = 0;
    int            checks = 0, errors = 0;

    // SRAM model plus a log of every scrub-engine access (host not requesting).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uncorr_valid) upulse <= upulse + 1;
        if (bank_req && !host_req) log_q.push_back('{cyc, bank_we, int'(bank_addr), bank_wdata});
        if (bank_req) begin
            if (bank_we) mem[bank_addr] <= bank_wdata;
            else         rdata <= mem[bank_addr];
        end
    end

    // Independent encoder: data fills non-power-of-two positions from 3 upward.
    function automatic logic [EW-1:0] enc_model(logic [DW-1:0] d);
        logic [EW-1:0] c;
        int k, s;
        c = '0; k = 0; s = 0;
        for (int p = 1; p < EW; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[k];
                if (d[k]) s = s ^ p;
                k++;
            end
        end
        for (int j = 0; j < 6; j++) c[1 << j] = s[j];
        c[0] = ^c[EW-1:1];
        return c;
    endfunction

    function automatic logic [DW-1:0] word_data(int a);
        return (a == 3) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | DW'(a));
    endfunction

    function automatic int find_acc(bit we, int a);
        foreach (log_q[i]) if (log_q[i].we == we && log_q[i].addr == a) return i;
        return -1;
    endfunction

    function automatic int count_acc(bit we, int a);
        int n;
        n = 0;
        foreach (log_q[i]) if (log_q[i].we == we && (a < 0 || log_q[i].addr == a)) n++;
        return n;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1; enable = 1'b0; host_req = 1'b0; host_we = 1'b0;
        host_addr = '0; host_wdata = '0;
        for (int i = 0; i < NW; i++) mem[i] <= enc_model(word_data(i));
        tick(2);
        rst = 1'b0;
        log_q.delete();
        pulse_base = upulse;
    endtask

    task automatic wait_read(int a, int budget, output int idx);
        idx = -1;
        for (int n = 0; n < budget && idx < 0; n++) begin
            tick(1);
            idx = find_acc(1'b0, a);
        end
        check($sformatf("wait_read_addr%0d", a), idx >= 0, 1);
    endtask

    mux_vec_t mux_tab[4];
    ecc_vec_t ecc_tab[5];

    initial begin
        int ri, wi, rel;
        ecc_vec_t v;

        mux_tab[0] = '{1'b0, 1'b1, 3'd5, 39'h12_3456_789A, 1'b0, 1'b0, 3'd0, 39'h0};
        mux_tab[1] = '{1'b1, 1'b0, 3'd2, 39'h0,           1'b1, 1'b0, 3'd2, 39'h0};
        mux_tab[2] = '{1'b1, 1'b1, 3'd7, 39'h55_AAAA_5555, 1'b1, 1'b1, 3'd7, 39'h55_AAAA_5555};
        mux_tab[3] = '{1'b1, 1'b1, 3'd0, 39'h7F_FFFF_FFFF, 1'b1, 1'b1, 3'd0, 39'h7F_FFFF_FFFF};

        ecc_tab[0] = '{addr: 3, flip: 39'h20,           exp_write: 1'b1, exp_uncorr: 0};
        ecc_tab[1] = '{addr: 1, flip: 39'h1,            exp_write: 1'b1, exp_uncorr: 0};
        ecc_tab[2] = '{addr: 7, flip: 39'h40_0000_0000, exp_write: 1'b1, exp_uncorr: 0};
        ecc_tab[3] = '{addr: 5, flip: 39'h204,          exp_write: 1'b0, exp_uncorr: 1};
        ecc_tab[4] = '{addr: 0, flip: 39'h40_0000_0001, exp_write: 1'b0, exp_uncorr: 1};

        // Reset state
        reset_dut();
        check("rst_busy", scrub_busy, 0);
        check("rst_corr", corr_cnt, 0);
        check("rst_uncorr", uncorr_cnt, 0);
        check("rst_uncorr_addr", uncorr_addr, 0);
        check("rst_uncorr_valid", uncorr_valid, 0);
        check("rst_bank_req", bank_req, 0);

        // Bank mux with the scrubber idle
        foreach (mux_tab[t]) begin
            host_req = mux_tab[t].req; host_we = mux_tab[t].we;
            host_addr = mux_tab[t].addr; host_wdata = mux_tab[t].wdata;
            #1;
            check($sformatf("mux%0d_gnt", t), host_gnt, mux_tab[t].req);
            check($sformatf("mux%0d_req", t), bank_req, mux_tab[t].exp_req);
            check($sformatf("mux%0d_we", t), bank_we, mux_tab[t].exp_we);
            check($sformatf("mux%0d_addr", t), bank_addr, mux_tab[t].exp_addr);
            check($sformatf("mux%0d_wdata", t), bank_wdata, mux_tab[t].exp_wdata);
            tick(1);
        end
        host_req = 1'b0; host_we = 1'b0;

        // Clean bank: reads 0..7,0 spaced 6 cycles, nothing written
        reset_dut();
        enable = 1'b1;
        tick(55);
        check("clean_read_count", log_q.size() >= 9, 1);
        check("clean_no_write", count_acc(1'b1, -1), 0);
        if (log_q.size() >= 9) begin
            for (int i = 0; i < 9; i++) begin
                check($sformatf("clean_addr%0d", i), log_q[i].addr, i % NW);
                if (i > 0) check($sformatf("clean_gap%0d", i), log_q[i].cyc - log_q[i-1].cyc, 6);
            end
        end
        check("clean_corr", corr_cnt, 0);
        check("clean_uncorr", uncorr_cnt, 0);

        // Single and double error cases
        foreach (ecc_tab[t]) begin
            v = ecc_tab[t];
            reset_dut();
            mem[v.addr] <= enc_model(word_data(v.addr)) ^ v.flip;
            enable = 1'b1;
            wait_read(v.addr, 80, ri);
            tick(3);
            wi = find_acc(1'b1, v.addr);
            if (v.exp_write) begin
                check($sformatf("ecc%0d_write", t), wi >= 0, 1);
                if (wi >= 0 && ri >= 0) begin
                    check($sformatf("ecc%0d_wdata", t), log_q[wi].wdata, enc_model(word_data(v.addr)));
                    check($sformatf("ecc%0d_latency", t), log_q[wi].cyc - log_q[ri].cyc, 2);
                end
            end else begin
                check($sformatf("ecc%0d_no_write", t), count_acc(1'b1, -1), 0);
            end
            check($sformatf("ecc%0d_corr", t), corr_cnt, v.exp_write);
            check($sformatf("ecc%0d_uncorr", t), uncorr_cnt, v.exp_uncorr);
            check($sformatf("ecc%0d_pulses", t), upulse - pulse_base, v.exp_uncorr);
            if (v.exp_uncorr > 0) check($sformatf("ecc%0d_uaddr", t), uncorr_addr, v.addr);
            if (v.exp_write) begin
                tick(50);
                check($sformatf("ecc%0d_reread", t), count_acc(1'b0, v.addr) >= 2, 1);
                check($sformatf("ecc%0d_one_write", t), count_acc(1'b1, -1), 1);
                check($sformatf("ecc%0d_corr_after", t), corr_cnt, 1);
                check($sformatf("ecc%0d_mem", t), mem[v.addr], enc_model(word_data(v.addr)));
            end
        end

        // Host holds the bank for 10 cycles across the scrub READ slot
        reset_dut();
        enable = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 3'd6;
        for (int n = 0; n < 10; n++) begin
            tick(1);
            check("hold_gnt", host_gnt, 1);
            check("hold_addr", bank_addr, 6);
            check("hold_we", bank_we, 0);
            if (n > 0) begin
                check("hold_rdata", host_rdata, enc_model(word_data(6)));
                check("hold_mirror", host_rdata, rdata);
            end
        end
        check("hold_stalled_busy", scrub_busy, 1);
        host_req = 1'b0;
        rel = cyc;
        for (int n = 0; n < 5 && log_q.size() == 0; n++) tick(1);
        check("hold_read_issued", log_q.size() > 0, 1);
        if (log_q.size() > 0) begin
            check("hold_read_cycle", log_q[0].cyc - rel, 0);
            check("hold_read_addr", log_q[0].addr, 0);
            check("hold_read_we", log_q[0].we, 0);
        end

        // Host write to the pointer address while the scrubber sits in WRITE
        reset_dut();
        mem[2] <= enc_model(word_data(2)) ^ (39'h1 << 10);
        enable = 1'b1;
        wait_read(2, 80, ri);
        tick(1);
        check("haz_scrub_we", bank_we, 1);
        check("haz_scrub_addr", bank_addr, 2);
        host_req = 1'b1; host_we = 1'b1; host_addr = 3'd2; host_wdata = enc_model(32'h0001_2345);
        tick(1);
        host_req = 1'b0; host_we = 1'b0;
        check("haz_idle", scrub_busy, 0);
        tick(5);
        check("haz_no_write", count_acc(1'b1, -1), 0);
        check("haz_corr", corr_cnt, 0);
        host_req = 1'b1; host_addr = 3'd2;
        tick(1);
        check("haz_readback", host_rdata, enc_model(32'h0001_2345));
        host_req = 1'b0;

        // Reset during DECODE of a single-error word
        reset_dut();
        mem[1] <= enc_model(word_data(1)) ^ 39'h1;
        enable = 1'b1;
        wait_read(1, 80, ri);
        rst = 1'b1;
        tick(1);
        check("rstdec_busy", scrub_busy, 0);
        check("rstdec_bank_req", bank_req, 0);
        check("rstdec_corr", corr_cnt, 0);
        check("rstdec_uncorr", uncorr_cnt, 0);
        check("rstdec_no_write", count_acc(1'b1, -1), 0);
        rst = 1'b0;
        log_q.delete();
        for (int n = 0; n < 20 && log_q.size() == 0; n++) tick(1);
        check("rstdec_restart", log_q.size() > 0, 1);
        if (log_q.size() > 0) check("rstdec_ptr", log_q[0].addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ecc_scrubber.md
Name: ecc_scrubber

Overview:
- Background scrubber for a single-port SRAM bank holding SECDED-encoded words (extended Hamming, the team's ecc_encode/ecc_decode code).
- Shares the bank between a host port and an internal scrub engine. It periodically reads each word, decodes it, and writes back the re-encoded corrected word on a single-bit error.
- Counts and reports double-bit (uncorrectable) errors. Sits directly in front of the SRAM macro; the host port has strict priority.

Parameters:
- DataWidth, 32, unencoded data width. EncWidth is derived: DataWidth + parity width + 1 (39 for 32, 72 for 64).
- NumWords, 256, bank depth. AddrWidth = $clog2(NumWords).
- ScrubInterval, 1024, idle cycles between scrub starts (≥1).
- CntWidth, 16, width of the error counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- enable_i  in  1  scrub enable
- host_req_i  in  1  host access request
- host_gnt_o  out  1  host grant, equal to host_req_i (combinational)
- host_we_i  in  1  host write enable
- host_addr_i  in  AddrWidth  host address
- host_wdata_i  in  EncWidth  host write data (already encoded)
- host_rdata_o  out  EncWidth  equals bank_rdata_i
- bank_req_o  out  1  SRAM request
- bank_we_o  out  1  SRAM write enable
- bank_addr_o  out  AddrWidth  SRAM address
- bank_wdata_o  out  EncWidth  SRAM write data
- bank_rdata_i  in  EncWidth  SRAM read data, valid 1 cycle after a read request
- scrub_busy_o  out  1  high when state != IDLE
- corr_cnt_o  out  CntWidth  corrected-error count, saturating
- uncorr_cnt_o  out  CntWidth  uncorrectable-error count, saturating
- uncorr_valid_o  out  1  one-cycle pulse on an uncorrectable error
- uncorr_addr_o  out  AddrWidth  address of the last uncorrectable error, held

Behaviour:
- Reset:
  - State IDLE; interval counter, scrub pointer and both error counters are 0.
  - uncorr_addr_o = 0; uncorr_valid_o = 0; scrub_busy_o = 0.
  - Reset mid-scrub abandons the operation; no writeback is issued.
- Bank mux:
  - If host_req_i, the bank signals are the host signals.
  - Otherwise the scrub engine drives them when it is in READ or WRITE.
  - Otherwise bank_req_o = 0, and the other bank outputs are 0.
- FSM states: IDLE, READ, DECODE, WRITE.
- IDLE:
  - While enable_i is high, the interval counter increments each cycle.
  - When the counter reaches ScrubInterval-1, it clears and the FSM goes to READ.
  - While enable_i is low, the counter is held at 0.
- READ:
  - Issues a read of the scrub pointer only in a cycle with host_req_i = 0. Otherwise it stalls in READ.
  - On issue, goes to DECODE.
- DECODE:
  - bank_rdata_i is valid this cycle and is decoded combinationally.
  - No error: pointer advances, FSM goes to IDLE.
  - Single error (data or parity bit): latch the re-encoded corrected word, go to WRITE.
  - Double error: uncorr_valid_o pulses this cycle, uncorr_addr_o <= pointer, uncorr_cnt_o increments, pointer advances, FSM goes to IDLE. No write is issued.
- WRITE:
  - Writes the latched word to the pointer address when host_req_i = 0. Otherwise it stalls.
  - On issue, corr_cnt_o increments, pointer advances, FSM goes to IDLE.
- Hazard: a host write (host_req_i & host_we_i) to the pointer address during DECODE or WRITE cancels the writeback. The pointer still advances, corr_cnt_o is unchanged, and the FSM goes to IDLE; the host data wins.
- Pointer wraps from NumWords-1 to 0.
- Counters saturate at 2^CntWidth-1.
- Deasserting enable_i mid-scrub does not abort the operation; the current word completes, then the FSM stays in IDLE.
- Worst-case scrub latency with no host traffic: READ→DECODE→WRITE→IDLE, one cycle each.

Test Plan:
- DataWidth=32, NumWords=8, ScrubInterval=4, enable_i=1, no host traffic, all words clean:
  - Required: a read at addresses 0,1,…,7,0 every 6 cycles (4 IDLE + READ + DECODE).
  - Required: no writes; both counters stay 0.
- Preload addr 3 with encode(0xDEADBEEF) with bit 5 flipped:
  - Required: on scrub of addr 3, a write of the exact encode(0xDEADBEEF) appears 2 cycles after the read.
  - Required: corr_cnt_o = 1; a later pass reads addr 3 clean.
- Preload addr 5 with bits 2 and 9 flipped:
  - Required: uncorr_valid_o pulses once; uncorr_addr_o = 5; uncorr_cnt_o = 1; no write to addr 5.
- Hold host_req_i=1 for 10 cycles across the scrub READ slot:
  - Required: host always granted; scrub read issues the first cycle host_req_i=0.
  - Required: host_rdata_o mirrors bank_rdata_i.
- Single error at addr 2; host writes 0x12345 (encoded) to addr 2 while the scrubber is in WRITE:
  - Required: the scrub writeback is cancelled and corr_cnt_o stays 0.
  - Required: a later read returns the host data.
- Assert rst_i during DECODE of a single-error word:
  - Required: no write issued; pointer and counters return to 0; scrub_busy_o = 0 the next cycle.
